// File: rtl/cc_rresp_arbiter.sv
// Round-robin arbiter sharing one read-data channel among N_REQ burst sources.
// Optional burst-length check enabled by defining CC_RARB_LAST_CHK_EN.
module cc_rresp_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_LEN = 8,
  localparam int unsigned GNT_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_rdata_i,
  input  logic [N_REQ-1:0]        req_rlast_i,
  input  logic [N_REQ-1:0]        req_rvalid_i,
  output logic [N_REQ-1:0]        req_rready_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [GNT_W-1:0]        rsrc_o,
  output logic                    busy_o,
  output logic                    err_o
);

  typedef enum logic [0:0] {S_IDLE, S_BURST} state_e;

  state_e           state_q, state_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GNT_W-1:0] winner;
  logic             win_found;
  logic             hs;

  assign hs = rvalid_o & rready_i;

  // First valid requester scanning upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    int unsigned      idx;
    logic [N_REQ-1:0] shifted;
    winner    = '0;
    win_found = 1'b0;
    idx       = 0;
    shifted   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      shifted = req_rvalid_i >> idx;
      if (!win_found && shifted[0]) begin
        winner    = GNT_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = winner;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (hs && rlast_o) begin
          state_d  = S_IDLE;
          rr_ptr_d = (gnt_q == GNT_W'(N_REQ - 1)) ? '0 : gnt_q + GNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output mux follows the registered grant only, so it cannot switch mid-beat.
  always_comb begin
    rdata_o      = '0;
    rlast_o      = 1'b0;
    rvalid_o     = 1'b0;
    req_rready_o = '0;
    rsrc_o       = gnt_q;
    busy_o       = (state_q == S_BURST);
    if (state_q == S_BURST) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (GNT_W'(j) == gnt_q) begin
          rdata_o         = req_rdata_i[j*DATA_W +: DATA_W];
          rlast_o         = req_rlast_i[j];
          rvalid_o        = req_rvalid_i[j];
          req_rready_o[j] = rready_i;
        end
      end
    end
  end

`ifdef CC_RARB_LAST_CHK_EN
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;
  logic             cnt_at_last;

  // Beat counter is held at zero in IDLE so every burst starts counting from 0.
  always_comb begin
    cnt_at_last = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    if (state_q == S_IDLE) begin
      beat_cnt_d = '0;
    end else if (hs) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      if (rlast_o != cnt_at_last) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
